// File: rtl/apu_mixer_out.sv
// Stereo output mixer: routes four channel DAC codes through the NR51 enables, scales by NR50,
// latches one 10-bit signed sample pair per 4-clock frame and drives first-order sigma-delta PDM.
module apu_mixer_out (
  input  logic       apuv_4mhz,
  input  logic       napu_reset,
  input  logic       apu_on,
  input  logic [3:0] ch1_out,
  input  logic [3:0] ch2_out,
  input  logic [3:0] ch3_out,
  input  logic [3:0] ch4_out,
  input  logic [3:0] ch_dac_en,
  input  logic [3:0] lmixer,
  input  logic [3:0] rmixer,
  input  logic [2:0] lvol,
  input  logic [2:0] rvol,
  output logic [9:0] sample_l,
  output logic [9:0] sample_r,
  output logic       sample_stb,
  output logic       pdm_l,
  output logic       pdm_r
);

  logic [1:0]        ph_q, ph_d;
  logic signed [6:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [9:0]        sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic              stb_q, stb_d;
  logic [9:0]        sd_l_q, sd_l_d, sd_r_q, sd_r_d;
  logic              pdm_l_q, pdm_l_d, pdm_r_q, pdm_r_d;

  logic [3:0]        code;
  logic signed [6:0] dac_s, contrib_l, contrib_r, sum_l, sum_r;
  logic [10:0]       sd_sum_l, sd_sum_r;

  // Signed frame sum (-60..60) times (vol+1); the product (-480..480) fits 10 bits exactly.
  function automatic logic [9:0] scale(input logic signed [6:0] sum, input logic [2:0] vol);
    logic signed [9:0] s_ext;
    logic signed [9:0] v_ext;
    s_ext = {{3{sum[6]}}, sum};
    v_ext = {6'b0, {1'b0, vol} + 4'd1};
    return s_ext * v_ext;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    code = ch1_out;
    case (ph_q)
      2'd1:    code = ch2_out;
      2'd2:    code = ch3_out;
      2'd3:    code = ch4_out;
      default: code = ch1_out;
    endcase

    dac_s     = ch_dac_en[ph_q] ? (7'sd15 - $signed({2'b00, code, 1'b0})) : 7'sd0;
    contrib_l = lmixer[ph_q] ? dac_s : 7'sd0;
    contrib_r = rmixer[ph_q] ? dac_s : 7'sd0;
    sum_l     = acc_l_q + contrib_l;
    sum_r     = acc_r_q + contrib_r;

    ph_d    = ph_q + 2'd1;
    acc_l_d = (ph_q == 2'd0) ? contrib_l : sum_l;
    acc_r_d = (ph_q == 2'd0) ? contrib_r : sum_r;

    stb_d      = (ph_q == 2'd3);
    sample_l_d = stb_d ? scale(sum_l, lvol) : sample_l_q;
    sample_r_d = stb_d ? scale(sum_r, rvol) : sample_r_q;

    // Offset-binary of the held sample (flip the sign bit) added into the modulator.
    sd_sum_l = {1'b0, sd_l_q} + {1'b0, ~sample_l_q[9], sample_l_q[8:0]};
    sd_sum_r = {1'b0, sd_r_q} + {1'b0, ~sample_r_q[9], sample_r_q[8:0]};
    sd_l_d   = sd_sum_l[9:0];
    sd_r_d   = sd_sum_r[9:0];
    pdm_l_d  = sd_sum_l[10];
    pdm_r_d  = sd_sum_r[10];
  end

  always_ff @(posedge apuv_4mhz) begin
    // Disabled master enable parks the block in exactly the reset state.
    if (!napu_reset || !apu_on) begin
      ph_q       <= 2'd0;
      acc_l_q    <= 7'sd0;
      acc_r_q    <= 7'sd0;
      sample_l_q <= 10'd0;
      sample_r_q <= 10'd0;
      stb_q      <= 1'b0;
      sd_l_q     <= 10'd0;
      sd_r_q     <= 10'd0;
      pdm_l_q    <= 1'b0;
      pdm_r_q    <= 1'b0;
    end else begin
      ph_q       <= ph_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      stb_q      <= stb_d;
      sd_l_q     <= sd_l_d;
      sd_r_q     <= sd_r_d;
      pdm_l_q    <= pdm_l_d;
      pdm_r_q    <= pdm_r_d;
    end
  end

  assign sample_l   = sample_l_q;
  assign sample_r   = sample_r_q;
  assign sample_stb = stb_q;
  assign pdm_l      = pdm_l_q;
  assign pdm_r      = pdm_r_q;

endmodule

// File: tb/tb_apu_mixer_out.sv
// Directed bench for apu_mixer_out: a behavioural model pushes expected sample pairs into a
// scoreboard queue as stimulus is applied; each DUT strobe pops and compares.
module tb_apu_mixer_out;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       apu_on = 1'b1;
  logic [3:0] ch_code [4];
  logic [3:0] ch_dac_en = 4'b0;
  logic [3:0] lmixer = 4'b0;
  logic [3:0] rmixer = 4'b0;
  logic [2:0] lvol = 3'd0;
  logic [2:0] rvol = 3'd0;
  logic [9:0] sample_l, sample_r;
  logic       sample_stb, pdm_l, pdm_r;

  typedef struct { int l; int r; } pair_t;
  pair_t sb_q[$];

  int checks = 0;
  int errors = 0;

  int m_ph = 0, m_acc_l = 0, m_acc_r = 0, m_samp_l = 0, m_samp_r = 0;
  int m_sd_l = 0, m_sd_r = 0, m_pdm_l = 0, m_pdm_r = 0, m_stb = 0;
  int ones;

  always #5 clk = ~clk;

  apu_mixer_out dut (
    .apuv_4mhz (clk),
    .napu_reset(rst_n),
    .apu_on    (apu_on),
    .ch1_out   (ch_code[0]),
    .ch2_out   (ch_code[1]),
    .ch3_out   (ch_code[2]),
    .ch4_out   (ch_code[3]),
    .ch_dac_en (ch_dac_en),
    .lmixer    (lmixer),
    .rmixer    (rmixer),
    .lvol      (lvol),
    .rvol      (rvol),
    .sample_l  (sample_l),
    .sample_r  (sample_r),
    .sample_stb(sample_stb),
    .pdm_l     (pdm_l),
    .pdm_r     (pdm_r)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge, clock the DUT, then compare 1 time unit after the edge.
  task automatic tick();
    int s, cl, cr, u;
    pair_t e;
    if (!rst_n || !apu_on) begin
      m_ph = 0; m_acc_l = 0; m_acc_r = 0; m_samp_l = 0; m_samp_r = 0;
      m_sd_l = 0; m_sd_r = 0; m_pdm_l = 0; m_pdm_r = 0; m_stb = 0;
    end else begin
      u = m_samp_l + 512; m_pdm_l = (m_sd_l + u) >= 1024 ? 1 : 0; m_sd_l = (m_sd_l + u) % 1024;
      u = m_samp_r + 512; m_pdm_r = (m_sd_r + u) >= 1024 ? 1 : 0; m_sd_r = (m_sd_r + u) % 1024;
      s  = ch_dac_en[m_ph] ? 15 - 2 * int'(ch_code[m_ph]) : 0;
      cl = lmixer[m_ph] ? s : 0;
      cr = rmixer[m_ph] ? s : 0;
      if (m_ph == 3) begin
        m_samp_l = (m_acc_l + cl) * (int'(lvol) + 1);
        m_samp_r = (m_acc_r + cr) * (int'(rvol) + 1);
        sb_q.push_back('{m_samp_l, m_samp_r});
        m_stb = 1;
      end else begin
        m_acc_l = (m_ph == 0) ? cl : m_acc_l + cl;
        m_acc_r = (m_ph == 0) ? cr : m_acc_r + cr;
        m_stb = 0;
      end
      m_ph = (m_ph + 1) % 4;
    end
    @(posedge clk);
    #1;
    check("sample_stb", sample_stb, m_stb);
    check("pdm_l", pdm_l, m_pdm_l);
    check("pdm_r", pdm_r, m_pdm_r);
    if (sample_stb === 1'b1) begin
      if (sb_q.size() == 0) check("scoreboard_underflow", 1, 0);
      else begin
        e = sb_q.pop_front();
        check("sample_l", $signed(sample_l), e.l);
        check("sample_r", $signed(sample_r), e.r);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_codes(input logic [3:0] c0, input logic [3:0] c1,
                           input logic [3:0] c2, input logic [3:0] c3);
    ch_code[0] = c0; ch_code[1] = c1; ch_code[2] = c2; ch_code[3] = c3;
  endtask

  initial begin
    set_codes(4'd0, 4'd0, 4'd0, 4'd0);

    // Reset state
    run(2);
    check("rst_sample_l", $signed(sample_l), 0);
    check("rst_sample_r", $signed(sample_r), 0);
    check("rst_stb", sample_stb, 0);
    check("rst_pdm_l", pdm_l, 0);
    rst_n = 1'b1;

    // Zero sample from reset: PDM alternates 0,1,0,1
    tick(); check("pdm_tog0", pdm_l, 0);
    tick(); check("pdm_tog1", pdm_l, 1);
    tick(); check("pdm_tog2", pdm_l, 0);
    tick(); check("pdm_tog3", pdm_l, 1);

    // Single channel, left only
    set_codes(4'd0, 4'd9, 4'd3, 4'd12);
    ch_dac_en = 4'b0001; lmixer = 4'b0001; rmixer = 4'b0000; lvol = 3'd7; rvol = 3'd2;
    run(12);
    check("single_l", $signed(sample_l), 120);
    check("single_r", $signed(sample_r), 0);

    // Full scale positive and PDM density
    set_codes(4'd0, 4'd0, 4'd0, 4'd0);
    ch_dac_en = 4'b1111; lmixer = 4'b1111; rmixer = 4'b1111; lvol = 3'd7; rvol = 3'd7;
    run(8);
    check("full_pos_l", $signed(sample_l), 480);
    check("full_pos_r", $signed(sample_r), 480);
    ones = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      if (pdm_l === 1'b1) ones++;
    end
    check("pdm_density_480", ones, 992);

    // Full scale negative at unity volume
    set_codes(4'd15, 4'd15, 4'd15, 4'd15);
    lvol = 3'd0; rvol = 3'd0;
    run(8);
    check("full_neg_l", $signed(sample_l), -60);
    check("full_neg_r", $signed(sample_r), -60);

    // DAC off blocks the routed channel, then powering it up
    set_codes(4'd0, 4'd0, 4'd15, 4'd0);
    ch_dac_en = 4'b1011; lmixer = 4'b0100; rmixer = 4'b0100; lvol = 3'd7; rvol = 3'd3;
    run(8);
    check("dac_off_l", $signed(sample_l), 0);
    check("dac_off_r", $signed(sample_r), 0);
    ch_dac_en = 4'b1111;
    run(8);
    check("dac_on_l", $signed(sample_l), -120);
    check("dac_on_r", $signed(sample_r), -60);

    // Reset for one edge while phase 2 is being serviced
    while (m_ph != 2) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_sample_l", $signed(sample_l), 0);
    check("midrst_pdm_l", pdm_l, 0);
    check("midrst_stb", sample_stb, 0);
    rst_n = 1'b1;
    run(3);
    check("midrst_no_early_stb", sample_stb, 0);
    tick();
    check("midrst_stb4", sample_stb, 1);
    check("midrst_val_l", $signed(sample_l), -120);

    // Master enable dropped for ten clocks
    apu_on = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("off_sample_l", $signed(sample_l), 0);
      check("off_pdm_r", pdm_r, 0);
    end
    apu_on = 1'b1;
    set_codes(4'd0, 4'd5, 4'd5, 4'd5);
    ch_dac_en = 4'b0001; lmixer = 4'b0001; rmixer = 4'b0001; lvol = 3'd7; rvol = 3'd1;
    run(3);
    check("reen_no_early_stb", sample_stb, 0);
    tick();
    check("reen_stb4", sample_stb, 1);
    check("reen_l", $signed(sample_l), 120);
    check("reen_r", $signed(sample_r), 30);
    run(8);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
